// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 keyboard receiver.
package ps2_pkg;

  // Frame deserializer states.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } ps2_state_t;

  // Scan-code prefixes: break (key release) and extended-key.
  localparam logic [7:0] PS2_BREAK = 8'hF0;
  localparam logic [7:0] PS2_EXT   = 8'hE0;

  // Data bits carried by one frame.
  localparam int PS2_FRAME_BITS = 8;

  // Odd parity holds when data plus parity bit contain an odd number of ones.
  function automatic logic ps2_parity_ok(input logic [7:0] data, input logic parity);
    return ^{data, parity};
  endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// Two-flop synchronizers for both PS/2 pins, a deglitch counter on the
// clock line and a one-cycle strobe on each filtered falling edge.
module ps2_line_filter #(
  parameter int unsigned FILTER_LEN = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic ps2_clock,
  input  logic ps2_data,
  output logic fclk,
  output logic strobe,
  output logic data_sync
);

  localparam logic [3:0] FILT_LAST = 4'(FILTER_LEN - 1);

  // Bit 0 carries the clock pin, bit 1 the data pin.
  logic [1:0] raw_pins;
  logic [1:0] meta_reg;
  logic [1:0] sync_reg;

  logic [3:0] cnt_reg, cnt_next;
  logic       fclk_reg, fclk_next;
  logic       strobe_reg;

  assign raw_pins = {ps2_data, ps2_clock};

  for (genvar gi = 0; gi < 2; gi++) begin : g_sync
    // Two-stage synchronizer per pin; idle lines are high, so reset to 1.
    always_ff @(posedge clock) begin
      if (reset) begin
        meta_reg[gi] <= 1'b1;
        sync_reg[gi] <= 1'b1;
      end else begin
        meta_reg[gi] <= raw_pins[gi];
        sync_reg[gi] <= meta_reg[gi];
      end
    end
  end

  // Filtered clock only follows the line after FILTER_LEN disagreeing samples.
  always_comb begin
    fclk_next = fclk_reg;
    cnt_next  = cnt_reg;
    if (sync_reg[0] == fclk_reg) begin
      cnt_next = 4'd0;
    end else if (cnt_reg == FILT_LAST) begin
      fclk_next = sync_reg[0];
      cnt_next  = 4'd0;
    end else begin
      cnt_next = cnt_reg + 4'd1;
    end
  end

  // Filter state and falling-edge strobe, aligned with the cycle fclk drops.
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_reg    <= 4'd0;
      fclk_reg   <= 1'b1;
      strobe_reg <= 1'b0;
    end else begin
      cnt_reg    <= cnt_next;
      fclk_reg   <= fclk_next;
      strobe_reg <= fclk_reg & ~fclk_next;
    end
  end

  assign fclk      = fclk_reg;
  assign strobe    = strobe_reg;
  assign data_sync = sync_reg[1];

endmodule

// File: rtl/ps2_receiver.sv
// PS/2 keyboard receiver: frame deserializer with parity/stop checking,
// mid-frame timeout and optional break/extended-prefix suppression.
module ps2_receiver
  import ps2_pkg::*;
#(
  parameter int unsigned FILTER_LEN     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 5000,
  parameter bit          SUPPRESS_BREAK = 1'b1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       ps2_clock,
  input  logic       ps2_data,
  output logic       ps2_key_pressed,
  output logic [7:0] ps2_out,
  output logic       frame_error
);

  localparam int unsigned TW         = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [2:0]  LAST_BIT   = 3'(PS2_FRAME_BITS - 1);

  logic fclk;
  logic strobe;
  logic data_sync;

  ps2_state_t     state_reg, state_next;
  logic [2:0]     bit_cnt_reg, bit_cnt_next;
  logic [7:0]     shreg_reg, shreg_next;
  logic           parity_reg, parity_next;
  logic [TW-1:0]  timeout_reg, timeout_next;
  logic           break_reg, break_next;
  logic [7:0]     out_reg, out_next;
  logic           key_reg, key_next;
  logic           err_reg, err_next;

  ps2_line_filter #(
    .FILTER_LEN(FILTER_LEN)
  ) u_filter (
    .clock    (clock),
    .reset    (reset),
    .ps2_clock(ps2_clock),
    .ps2_data (ps2_data),
    .fclk     (fclk),
    .strobe   (strobe),
    .data_sync(data_sync)
  );

  // A strobe marks the cycle fclk has just fallen, so fclk must be low then.
  assert property (@(posedge clock) disable iff (reset) strobe |-> !fclk);

  // Frame sequencing, timeout supervision and delivery decision.
  always_comb begin
    state_next   = state_reg;
    bit_cnt_next = bit_cnt_reg;
    shreg_next   = shreg_reg;
    parity_next  = parity_reg;
    timeout_next = '0;
    break_next   = break_reg;
    out_next     = out_reg;
    key_next     = 1'b0;
    err_next     = 1'b0;

    if (state_reg != IDLE && !strobe) begin
      timeout_next = timeout_reg + TW'(1);
    end

    case (state_reg)
      IDLE: begin
        // A high start bit is a spurious edge and is ignored.
        if (strobe && !data_sync) begin
          state_next   = DATA;
          bit_cnt_next = 3'd0;
        end
      end
      DATA: begin
        if (strobe) begin
          shreg_next   = {data_sync, shreg_reg[7:1]};
          bit_cnt_next = bit_cnt_reg + 3'd1;
          if (bit_cnt_reg == LAST_BIT) begin
            state_next = PARITY;
          end
        end
      end
      PARITY: begin
        if (strobe) begin
          parity_next = data_sync;
          state_next  = STOP;
        end
      end
      STOP: begin
        if (strobe) begin
          state_next = IDLE;
          if (data_sync && ps2_parity_ok(shreg_reg, parity_reg)) begin
            if (SUPPRESS_BREAK) begin
              if (shreg_reg == PS2_BREAK) begin
                break_next = 1'b1;
              end else if (shreg_reg == PS2_EXT) begin
                // Extended prefix is dropped without touching break state.
              end else if (break_reg) begin
                break_next = 1'b0;
              end else begin
                out_next = shreg_reg;
                key_next = 1'b1;
              end
            end else begin
              out_next = shreg_reg;
              key_next = 1'b1;
            end
          end else begin
            err_next   = 1'b1;
            break_next = 1'b0;
          end
        end
      end
      default: state_next = IDLE;
    endcase

    // Stalled frame: abandon it. A strobe in the same cycle takes priority.
    if (state_reg != IDLE && !strobe && timeout_reg == TO_LAST) begin
      state_next   = IDLE;
      err_next     = 1'b1;
      break_next   = 1'b0;
      timeout_next = '0;
    end
  end

  // Receiver state registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg   <= IDLE;
      bit_cnt_reg <= 3'd0;
      shreg_reg   <= 8'h00;
      parity_reg  <= 1'b0;
      timeout_reg <= '0;
      break_reg   <= 1'b0;
      out_reg     <= 8'h00;
      key_reg     <= 1'b0;
      err_reg     <= 1'b0;
    end else begin
      state_reg   <= state_next;
      bit_cnt_reg <= bit_cnt_next;
      shreg_reg   <= shreg_next;
      parity_reg  <= parity_next;
      timeout_reg <= timeout_next;
      break_reg   <= break_next;
      out_reg     <= out_next;
      key_reg     <= key_next;
      err_reg     <= err_next;
    end
  end

  assign ps2_key_pressed = key_reg;
  assign ps2_out         = out_reg;
  assign frame_error     = err_reg;

endmodule

// File: tb/tb_ps2_receiver.sv
// Randomized bench for ps2_receiver: two instances (break suppression on and
// off) share the PS/2 pins and are compared against a frame-level model.
module tb_ps2_receiver;

  localparam int F    = 4;
  localparam int TO   = 400;
  localparam int HALF = 40;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ps2_c = 1'b1;
  logic ps2_d = 1'b1;

  logic       key_p [0:1];
  logic [7:0] out_b [0:1];
  logic       err_p [0:1];

  int cyc = 0;
  int key_cnt [0:1];
  int err_cnt [0:1];
  int key_cyc [0:1];
  int err_cyc [0:1];
  int overlap = 0;
  int fall_cyc = 0;
  int total = 0;
  int bad = 0;

  // Frame-level model state
  logic [7:0] m_out [0:1];
  bit         m_bp;

  always #5 clk = ~clk;

  ps2_receiver #(.FILTER_LEN(F), .TIMEOUT_CYCLES(TO), .SUPPRESS_BREAK(1'b1)) u_dut (
    .clock(clk), .reset(rst), .ps2_clock(ps2_c), .ps2_data(ps2_d),
    .ps2_key_pressed(key_p[0]), .ps2_out(out_b[0]), .frame_error(err_p[0]));

  ps2_receiver #(.FILTER_LEN(F), .TIMEOUT_CYCLES(TO), .SUPPRESS_BREAK(1'b0)) u_dut_raw (
    .clock(clk), .reset(rst), .ps2_clock(ps2_c), .ps2_data(ps2_d),
    .ps2_key_pressed(key_p[1]), .ps2_out(out_b[1]), .frame_error(err_p[1]));

  always @(posedge clk) cyc <= cyc + 1;

  // Pulse monitor, sampled on the falling edge
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (key_p[i] === 1'b1) begin key_cnt[i]++; key_cyc[i] = cyc; end
      if (err_p[i] === 1'b1) begin err_cnt[i]++; err_cyc[i] = cyc; end
      if (key_p[i] === 1'b1 && err_p[i] === 1'b1) overlap++;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive_bit(input logic d);
    ps2_d = d;
    wait_cyc(HALF);
    ps2_c = 1'b0;
    fall_cyc = cyc;
    wait_cyc(HALF);
    ps2_c = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit par_flip, input bit stop_v);
    logic par;
    par = ~(^b) ^ par_flip;
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    drive_bit(par);
    drive_bit(stop_v);
    ps2_d = 1'b1;
  endtask

  // Sends one frame, advances the model, and checks pulses, data and latency.
  task automatic frame_and_check(input string tag, input logic [7:0] b, input bit par_flip, input bit stop_v);
    int k0 [0:1];
    int e0 [0:1];
    bit valid;
    int del [0:1];
    int er;
    for (int i = 0; i < 2; i++) begin k0[i] = key_cnt[i]; e0[i] = err_cnt[i]; end
    send_frame(b, par_flip, stop_v);
    wait_cyc(10);

    valid = !par_flip && stop_v;
    del[0] = 0;
    del[1] = 0;
    er = 0;
    if (valid) begin
      del[1] = 1;
      if (b == 8'hF0) m_bp = 1'b1;
      else if (b == 8'hE0) begin end
      else if (m_bp) m_bp = 1'b0;
      else del[0] = 1;
    end else begin
      er = 1;
      m_bp = 1'b0;
    end
    for (int i = 0; i < 2; i++) if (del[i] == 1) m_out[i] = b;

    for (int i = 0; i < 2; i++) begin
      check($sformatf("%s.key%0d", tag, i), key_cnt[i] - k0[i], del[i]);
      check($sformatf("%s.err%0d", tag, i), err_cnt[i] - e0[i], er);
      check($sformatf("%s.out%0d", tag, i), {24'h0, out_b[i]}, {24'h0, m_out[i]});
      if (del[i] == 1) check($sformatf("%s.klat%0d", tag, i), key_cyc[i] - fall_cyc, 3 + F);
      if (er == 1) check($sformatf("%s.elat%0d", tag, i), err_cyc[i] - fall_cyc, 3 + F);
    end
    $display("frame %s byte=%02h par_flip=%0d stop=%0d out=%02h/%02h", tag, b, par_flip, stop_v, out_b[0], out_b[1]);
  endtask

  // Start bit plus n data bits, then the line stays idle.
  task automatic partial_frame(input int n);
    drive_bit(1'b0);
    for (int i = 0; i < n; i++) drive_bit(1'($urandom_range(0, 1)));
    ps2_d = 1'b1;
  endtask

  task automatic check_outputs_quiet(input string tag, input int k0a, input int k0b, input int e0a, input int e0b, input int exp_err);
    check({tag, ".key0"}, key_cnt[0] - k0a, 0);
    check({tag, ".key1"}, key_cnt[1] - k0b, 0);
    check({tag, ".err0"}, err_cnt[0] - e0a, exp_err);
    check({tag, ".err1"}, err_cnt[1] - e0b, exp_err);
    check({tag, ".out0"}, {24'h0, out_b[0]}, {24'h0, m_out[0]});
    check({tag, ".out1"}, {24'h0, out_b[1]}, {24'h0, m_out[1]});
    $display("event %s out=%02h/%02h", tag, out_b[0], out_b[1]);
  endtask

  initial begin
    int ka, kb, ea, eb, lat;
    logic [7:0] rb;
    int r;
    for (int i = 0; i < 2; i++) begin
      key_cnt[i] = 0; err_cnt[i] = 0; key_cyc[i] = 0; err_cyc[i] = 0; m_out[i] = 8'h00;
    end
    m_bp = 1'b0;

    rst = 1'b1;
    wait_cyc(5);
    rst = 1'b0;
    wait_cyc(2);
    for (int i = 0; i < 2; i++) begin
      check($sformatf("rst.key%0d", i), {31'h0, key_p[i]}, 0);
      check($sformatf("rst.err%0d", i), {31'h0, err_p[i]}, 0);
      check($sformatf("rst.out%0d", i), {24'h0, out_b[i]}, 0);
    end
    wait_cyc(20);

    // Basic frame
    frame_and_check("basic_1c", 8'h1C, 1'b0, 1'b1);
    // Break sequence and extended prefix
    frame_and_check("brk_f0", 8'hF0, 1'b0, 1'b1);
    frame_and_check("brk_1c", 8'h1C, 1'b0, 1'b1);
    frame_and_check("again_1c", 8'h1C, 1'b0, 1'b1);
    frame_and_check("ext_e0", 8'hE0, 1'b0, 1'b1);
    frame_and_check("ext_74", 8'h74, 1'b0, 1'b1);
    // Bad parity and bad stop
    frame_and_check("badpar", 8'h1C, 1'b1, 1'b1);
    frame_and_check("badstop", 8'h3A, 1'b0, 1'b0);
    // Break pending is cleared by an invalid frame
    frame_and_check("f0_then_err", 8'hF0, 1'b0, 1'b1);
    frame_and_check("err_clears", 8'h11, 1'b1, 1'b1);
    frame_and_check("after_clear", 8'h22, 1'b0, 1'b1);

    // Glitch one cycle shorter than the filter: no strobe, so no frame starts
    ka = key_cnt[0]; kb = key_cnt[1]; ea = err_cnt[0]; eb = err_cnt[1];
    ps2_d = 1'b0;
    ps2_c = 1'b0;
    wait_cyc(F - 1);
    ps2_c = 1'b1;
    wait_cyc(F + 6);
    ps2_d = 1'b1;
    wait_cyc(TO + 40);
    check_outputs_quiet("glitch_short", ka, kb, ea, eb, 0);
    frame_and_check("post_glitch_29", 8'h29, 1'b0, 1'b1);

    // Pulse exactly the filter length: a start bit is seen, then the frame stalls
    ka = key_cnt[0]; kb = key_cnt[1]; ea = err_cnt[0]; eb = err_cnt[1];
    ps2_d = 1'b0;
    ps2_c = 1'b0;
    wait_cyc(F);
    ps2_c = 1'b1;
    wait_cyc(F + 6);
    ps2_d = 1'b1;
    wait_cyc(TO + 40);
    m_bp = 1'b0;
    check_outputs_quiet("glitch_full", ka, kb, ea, eb, 1);

    // Timeout after four data bits
    frame_and_check("pre_to_f0", 8'hF0, 1'b0, 1'b1);
    ka = key_cnt[0]; kb = key_cnt[1]; ea = err_cnt[0]; eb = err_cnt[1];
    partial_frame(4);
    wait_cyc(TO + 20);
    m_bp = 1'b0;
    check_outputs_quiet("timeout", ka, kb, ea, eb, 1);
    lat = err_cyc[0] - fall_cyc;
    check("timeout.lat", {31'h0, 1'(lat >= TO + 2 + F && lat <= TO + 4 + F)}, 1);
    frame_and_check("post_to_5a", 8'h5A, 1'b0, 1'b1);

    // Reset in the middle of a frame
    frame_and_check("pre_rst_f0", 8'hF0, 1'b0, 1'b1);
    ka = key_cnt[0]; kb = key_cnt[1]; ea = err_cnt[0]; eb = err_cnt[1];
    partial_frame(4);
    rst = 1'b1;
    wait_cyc(1);
    rst = 1'b0;
    wait_cyc(20);
    m_out[0] = 8'h00;
    m_out[1] = 8'h00;
    m_bp = 1'b0;
    check_outputs_quiet("midrst", ka, kb, ea, eb, 0);
    frame_and_check("post_rst_16", 8'h16, 1'b0, 1'b1);

    // Randomized traffic
    for (int n = 0; n < 40; n++) begin
      r = $urandom_range(0, 9);
      if (r < 2) rb = 8'hF0;
      else if (r == 2) rb = 8'hE0;
      else rb = 8'($urandom_range(0, 255));
      frame_and_check($sformatf("rnd%0d", n), rb, ($urandom_range(0, 7) == 0), ($urandom_range(0, 9) != 0));
    end

    check("mutex", overlap, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ps2_receiver.md
# ps2_receiver

Receives scan-code frames from a PS/2 keyboard and presents each accepted byte to the processor core on `ps2_out`, with a one-cycle `ps2_key_pressed` strobe. The block sits directly upstream of the processor's `ps2_key_pressed`/`ps2_out` inputs. It synchronizes and deglitches the asynchronous PS/2 lines, deserializes 11-bit frames, checks parity and the stop bit, and recovers from stalled frames. Break sequences (F0 xx) and the extended prefix (E0) can optionally be filtered out.

## Interface
- `FILTER_LEN`, default 4: consecutive samples required before the filtered `ps2_clock` changes value (1..15).
- `TIMEOUT_CYCLES`, default 5000: idle cycles allowed mid-frame before abort (100 µs at 50 MHz).
- `SUPPRESS_BREAK`, default 1: 1 drops F0, E0 and the byte following F0; 0 delivers every valid byte.
- `clock`, in, 1: single system clock, rising edge.
- `reset`, in, 1: synchronous, active-high.
- `ps2_clock`, in, 1: raw PS/2 clock pin, asynchronous.
- `ps2_data`, in, 1: raw PS/2 data pin, asynchronous.
- `ps2_key_pressed`, out, 1: one-cycle pulse when a byte is delivered.
- `ps2_out`, out, 8: last delivered byte; held until the next delivery.
- `frame_error`, out, 1: one-cycle pulse on a parity, stop-bit or timeout failure.

## Operation
- **Synchronization.** Both pins pass through a 2-flop synchronizer.
- **Clock filter.** The filtered clock `fclk` resets to 1. It takes the synchronized value only after FILTER_LEN consecutive cycles of disagreement; any agreeing sample clears the count.
- **Bit strobe.** `strobe` is asserted in the cycle `fclk` goes 1→0. The synchronized data is sampled on `strobe` only.
- **Frame FSM** (bits LSB first):
  - IDLE: on strobe with data=0, go to DATA with bit_cnt=0. On strobe with data=1, stay in IDLE (spurious edge ignored).
  - DATA: on strobe, shift right: shreg = {d, shreg[7:1]} and increment bit_cnt. On the 8th bit, go to PARITY.
  - PARITY: on strobe, latch the parity bit and go to STOP.
  - STOP: on strobe, the frame is valid iff d=1 and (^shreg ^ parity)=1 (odd parity). Return to IDLE in either case.
- **Timeout.** In any state other than IDLE, a counter increments every cycle without a strobe and clears on each strobe. When it reaches TIMEOUT_CYCLES: go to IDLE, pulse `frame_error`, clear break_pending.
- **Invalid frame.** Pulse `frame_error`, suppress `ps2_key_pressed`, leave `ps2_out` unchanged, clear break_pending.
- **Delivery when SUPPRESS_BREAK=1** (valid byte b):
  - b=F0: set break_pending, no delivery.
  - b=E0: no delivery; break_pending unchanged.
  - else if break_pending: clear it, no delivery.
  - else: deliver b.
- **Delivery when SUPPRESS_BREAK=0.** Every valid byte is delivered; break_pending stays 0.
- **Delivery action.** `ps2_out` ← b and `ps2_key_pressed` ← 1 for exactly one cycle.

## Timing
- **Reset values:** `ps2_key_pressed`=0, `ps2_out`=8'h00, `frame_error`=0, state=IDLE, `fclk`=1, bit_cnt=0, break_pending=0, timeout counter=0, filter counter=0, synchronizers=1.
- **Reset mid-frame:** the partial frame is discarded with no pulse of either strobe. The next complete frame is received normally.
- **Edge-to-strobe latency:** pin falls → strobe asserted 2+FILTER_LEN cycles later.
- **Delivery timing:** `ps2_out`/`ps2_key_pressed` update on the clock edge after the stop-bit strobe, which is 3+FILTER_LEN cycles after the pin edge. `frame_error` has the same latency.
- **Mutual exclusion:** `ps2_key_pressed` and `frame_error` are never high in the same cycle.
- **Back-to-back frames:** minimum spacing is one PS/2 bit period; no internal backpressure. The consumer must sample on the strobe cycle.
- **Simultaneous timeout and strobe:** the strobe wins and the counter clears.
- **Pulse width:** glitches shorter than FILTER_LEN cycles on `ps2_clock` never produce a strobe.

## Structure
- Package `ps2_pkg` holds:
  - the state enum (IDLE, DATA, PARITY, STOP);
  - the constants PS2_BREAK=8'hF0 and PS2_EXT=8'hE0;
  - the frame bit count, 8.
- Sub-module `ps2_line_filter`: synchronizer, deglitch counter and falling-edge strobe for one line. Outputs are `fclk`, `strobe` and the synchronized data. The top level contains the FSM, timeout and delivery logic.

## Test plan
- Frame for 0x1C (start 0; data 0,0,1,1,1,0,0,0; parity 0; stop 1) at 10 µs/bit → one `ps2_key_pressed` pulse, `ps2_out`=8'h1C, `frame_error` stays 0.
- With SUPPRESS_BREAK=1, send F0, 1C, then 1C → no pulse for the first two frames, `ps2_out` holds 8'h1C, then exactly one pulse. Sending E0, 74 → a single pulse with `ps2_out`=8'h74.
- Send 0x1C with parity bit 1 → `frame_error` pulses once, no key pulse, `ps2_out` unchanged.
- Drive `ps2_clock` low for FILTER_LEN-1 cycles while idle → no strobe. A following frame 0x29 → pulse, `ps2_out`=8'h29.
- Stop after 4 data bits for TIMEOUT_CYCLES cycles → `frame_error` pulse and return to IDLE. A next frame 0x5A → pulse, `ps2_out`=8'h5A.
- Assert `reset` for one cycle after 5 bits → all outputs return to reset values, no pulses. A next frame 0x16 → exactly one pulse, `ps2_out`=8'h16.
